// File: rtl/branch_seq.sv
// Conditional-branch control sequencer: steps T3..T6 of the branch microsequence and records the outcome.
// Optional taken/not-taken statistics counters are built when BRANCH_SEQ_STATS_EN is defined.
module branch_seq #(
  parameter logic [4:0] BR_OPCODE = 5'b10010,
  parameter int         CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             taken,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [2:0] {IDLE, T3, T4, T5, T6, FIN} stateT;

  stateT state, nextState;
  logic  errReg, takenReg;
  logic  isBranch;
  logic  unusedIrBits;

  // Only the opcode field matters here; the condition field is decoded by the CON logic.
  assign isBranch     = (ir[31:27] == BR_OPCODE);
  assign unusedIrBits = ^ir[26:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && isBranch) nextState = T3;
      T3:      nextState = T4;
      T4:      nextState = T5;
      T5:      nextState = T6;
      T6:      nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strobes come from the state alone; pc_in additionally qualifies on the live CON value in T6.
  always_comb begin
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      T3: begin
        gra    = 1'b1;
        r_out  = 1'b1;
        con_in = 1'b1;
      end
      T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
      end
      T6: begin
        zlow_out = 1'b1;
        pc_in    = con_out;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      errReg   <= 1'b0;
      takenReg <= 1'b0;
    end else begin
      errReg <= (state == IDLE) && start && !isBranch;
      if (state == T6) takenReg <= con_out;
    end
  end

  assign err   = errReg;
  assign taken = takenReg;

`ifdef BRANCH_SEQ_STATS_EN
  logic [CNT_W-1:0] takenCntReg, ntakenCntReg;

  // A clear has priority over a coincident increment; both counters stick at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      takenCntReg  <= '0;
      ntakenCntReg <= '0;
    end else if (stats_clr) begin
      takenCntReg  <= '0;
      ntakenCntReg <= '0;
    end else if (state == T6) begin
      if (con_out) begin
        if (!(&takenCntReg)) takenCntReg <= takenCntReg + CNT_W'(1);
      end else begin
        if (!(&ntakenCntReg)) ntakenCntReg <= ntakenCntReg + CNT_W'(1);
      end
    end
  end

  assign taken_cnt  = takenCntReg;
  assign ntaken_cnt = ntakenCntReg;
`else
  logic unusedStatsClr;

  assign unusedStatsClr = stats_clr;
  assign taken_cnt      = '0;
  assign ntaken_cnt     = '0;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: taken/not-taken sequences, illegal opcode, async reset, restart and statistics.
module tb_branch_seq;

  localparam int          CNT_W   = 2;
  localparam logic [31:0] IR_BR   = 32'h9000_0005;
  localparam logic [31:0] IR_BAD  = 32'h0800_0000;

  // Strobe vector: {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,zlow_out,pc_in,done,busy,err}
  localparam logic [12:0] S_IDLE = 13'b0000000000000;
  localparam logic [12:0] S_ERR  = 13'b0000000000001;
  localparam logic [12:0] S_T3   = 13'b1110000000010;
  localparam logic [12:0] S_T4   = 13'b0001100000010;
  localparam logic [12:0] S_T5   = 13'b0000011100010;
  localparam logic [12:0] S_T6T  = 13'b0000000011010;
  localparam logic [12:0] S_T6N  = 13'b0000000010010;
  localparam logic [12:0] S_FIN  = 13'b0000000000110;

`ifdef BRANCH_SEQ_STATS_EN
  localparam logic statsOn = 1'b1;
`else
  localparam logic statsOn = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n, start, con_out, stats_clr;
  logic [31:0]      ir;
  logic             busy, done, err, taken;
  logic             gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in;
  logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

  int checks = 0;
  int errors = 0;

  branch_seq #(.BR_OPCODE(5'b10010), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ir(ir), .con_out(con_out),
    .busy(busy), .done(done), .err(err), .taken(taken),
    .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
    .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlow_out(zlow_out), .pc_in(pc_in),
    .stats_clr(stats_clr), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [12:0] strobes();
    return {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, done, busy, err};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One complete branch; ir and con_out are disturbed outside their sampling windows.
  task automatic applyStimulus(input logic con, input string tag);
    ir      = IR_BR;
    con_out = ~con;
    start   = 1'b1;
    tick();
    start = 1'b0;
    ir    = IR_BAD;
    checkOutput({tag, " T3"}, 32'(strobes()), 32'(S_T3));
    tick();
    checkOutput({tag, " T4"}, 32'(strobes()), 32'(S_T4));
    tick();
    checkOutput({tag, " T5"}, 32'(strobes()), 32'(S_T5));
    tick();
    con_out = con;
    #1;
    checkOutput({tag, " T6"}, 32'(strobes()), con ? 32'(S_T6T) : 32'(S_T6N));
    tick();
    con_out = ~con;
    checkOutput({tag, " FIN"}, 32'(strobes()), 32'(S_FIN));
    checkOutput({tag, " taken"}, 32'(taken), 32'(con));
    tick();
    checkOutput({tag, " idle"}, 32'(strobes()), 32'(S_IDLE));
    checkOutput({tag, " taken hold"}, 32'(taken), 32'(con));
  endtask

  initial begin
    logic [12:0] restartExp [14];

    reset_n   = 1'b0;
    start     = 1'b0;
    con_out   = 1'b0;
    stats_clr = 1'b0;
    ir        = 32'h0;
    #2;
    checkOutput("reset strobes", 32'(strobes()), 32'(S_IDLE));
    checkOutput("reset taken", 32'(taken), 32'd0);
    checkOutput("reset taken_cnt", 32'(taken_cnt), 32'd0);
    checkOutput("reset ntaken_cnt", 32'(ntaken_cnt), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    applyStimulus(1'b1, "taken");
    applyStimulus(1'b0, "ntaken");

    // Illegal opcode: one-cycle err, no sequence.
    ir    = IR_BAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("illegal err", 32'(strobes()), 32'(S_ERR));
    tick();
    checkOutput("illegal after", 32'(strobes()), 32'(S_IDLE));

    // Async reset during T5, with a previous taken=1 to be cleared.
    applyStimulus(1'b1, "pre-reset");
    ir      = IR_BR;
    con_out = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("mid T5", 32'(strobes()), 32'(S_T5));
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset strobes", 32'(strobes()), 32'(S_IDLE));
    checkOutput("mid reset taken", 32'(taken), 32'd0);
    checkOutput("mid reset taken_cnt", 32'(taken_cnt), 32'd0);
    tick();
    checkOutput("mid reset no pc_in", 32'(strobes()), 32'(S_IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    applyStimulus(1'b1, "post-reset");

    // Start held for 8 sampling edges: second run begins after the idle cycle following FIN.
    restartExp = '{S_T3, S_T4, S_T5, S_T6T, S_FIN, S_IDLE, S_T3, S_T4, S_T5, S_T6T, S_FIN,
                   S_IDLE, S_IDLE, S_IDLE};
    ir      = IR_BR;
    con_out = 1'b1;
    start   = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 7) start = 1'b0;
      checkOutput($sformatf("restart cyc%0d", i + 1), 32'(strobes()), 32'(restartExp[i]));
    end

    // Statistics with 2-bit saturating counters.
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checkOutput("stats clr taken", 32'(taken_cnt), 32'd0);
    checkOutput("stats clr ntaken", 32'(ntaken_cnt), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, $sformatf("stats%0d", i));
    checkOutput("stats sat taken", 32'(taken_cnt), statsOn ? 32'd3 : 32'd0);
    checkOutput("stats sat ntaken", 32'(ntaken_cnt), 32'd0);
    applyStimulus(1'b0, "stats nt");
    checkOutput("stats ntaken one", 32'(ntaken_cnt), statsOn ? 32'd1 : 32'd0);
    checkOutput("stats taken keep", 32'(taken_cnt), statsOn ? 32'd3 : 32'd0);
    stats_clr = 1'b1;
    applyStimulus(1'b1, "stats clr-win");
    stats_clr = 1'b0;
    checkOutput("clr wins taken", 32'(taken_cnt), 32'd0);
    checkOutput("clr wins ntaken", 32'(ntaken_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
